// File: rtl/seg_pkg.sv
// seg_pkg: shared decode table, scan state type and polarity helpers for the seven-segment scanner
package seg_pkg;

    // Index 0 is the rightmost entry; patterns are {dp,g,f,e,d,c,b,a} active-high
    localparam logic [15:0][7:0] HEX7_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    typedef enum logic {BLANK = 1'b0, ON = 1'b1} scan_state_e;

    function automatic logic [7:0] SEG_OFF(input logic pol);
        return pol ? 8'h00 : 8'hFF;
    endfunction

    function automatic logic DIG_OFF(input logic pol);
        return ~pol;
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// seg_hex_dec: nibble plus decimal point to active-high {dp,g..a} pattern
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {dp_i, HEX7_TABLE[nib_i][6:0]};

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed hex display scanner with dead-time blanking and frame snapshots.
// Define SEG_LZB_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIG     = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter bit SEG_POL   = 1'b1,
    parameter bit DIG_POL   = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [4*N_DIG-1:0] i_data,
    input  logic [N_DIG-1:0]   i_dp,
    input  logic [N_DIG-1:0]   i_en_mask,
    output logic [7:0]         SEG,
    output logic [N_DIG-1:0]   DIG,
    output logic               o_frame
);

    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = N_DIG > 1 ? $clog2(N_DIG) : 1;
    localparam int BL = BLANK_CYC > 0 ? BLANK_CYC : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    scan_state_e             state_q, state_d;
    logic                    first_q;
    logic [N_DIG-1:0][3:0]   data_q;
    logic [N_DIG-1:0]        dp_q, en_q, lz;
    logic                    slot_end, frame_end, show;
    logic [7:0]              dec, seg_hi, seg_d;
    logic [N_DIG-1:0]        dig_hot, dig_d;

    assign slot_end  = cnt_q == CNT_LAST;
    assign frame_end = slot_end && idx_q == IDX_LAST;
    assign cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    assign idx_d     = slot_end ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
    assign state_d   = (BLANK_CYC > 0 && cnt_d < CW'(BL)) ? BLANK : ON;

`ifdef SEG_LZB_EN
    logic zero_run;

    // A digit is a leading zero while every nibble from the top down to it is zero
    always_comb begin
        lz = '0;
        zero_run = 1'b1;
        for (int k = N_DIG - 1; k > 0; k--) begin
            zero_run = zero_run && data_q[k] == 4'h0;
            lz[k] = zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    seg_hex_dec u_dec (
        .nib_i (data_q[idx_q]),
        .dp_i  (dp_q[idx_q]),
        .seg_o (dec)
    );

    // A blanked leading zero still shows its decimal point
    assign show    = state_q == ON && en_q[idx_q] && (!lz[idx_q] || dp_q[idx_q]);
    assign seg_hi  = lz[idx_q] ? {dp_q[idx_q], 7'h00} : dec;
    assign seg_d   = show ? (SEG_POL ? seg_hi : ~seg_hi) : SEG_OFF(SEG_POL);
    assign dig_hot = N_DIG'(1) << idx_q;
    assign dig_d   = show ? (DIG_POL ? dig_hot : ~dig_hot) : {N_DIG{DIG_OFF(DIG_POL)}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= BLANK;
            first_q <= 1'b1;
            data_q  <= '0;
            dp_q    <= '0;
            en_q    <= '0;
            SEG     <= SEG_OFF(SEG_POL);
            DIG     <= {N_DIG{DIG_OFF(DIG_POL)}};
            o_frame <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            first_q <= 1'b0;
            if (first_q || frame_end) begin
                data_q <= i_data;
                dp_q   <= i_dp;
                en_q   <= i_en_mask;
            end
            SEG     <= seg_d;
            DIG     <= dig_d;
            o_frame <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux with N_DIG=3, SCAN_DIV=8, BLANK_CYC=2
module tb_seg_scan_mux;

    typedef struct {
        logic [7:0] seg;
        logic [2:0] dig;
        logic       frame;
        string      tag;
    } exp_t;

`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] i_data = '0;
    logic [2:0]  i_dp = '0;
    logic [2:0]  i_en_mask = '0;
    logic [7:0]  SEG;
    logic [2:0]  DIG;
    logic        o_frame;

    logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    exp_t  sb[$];
    exp_t  cur;
    bit    sb_active = 1'b0;
    string cur_test = "init";
    int    n_cmp = 0;
    int    n_bad = 0;

    seg_scan_mux #(
        .N_DIG(3), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_POL(1'b1), .DIG_POL(1'b0)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_data    (i_data),
        .i_dp      (i_dp),
        .i_en_mask (i_en_mask),
        .SEG       (SEG),
        .DIG       (DIG),
        .o_frame   (o_frame)
    );

    always #5 clk = ~clk;

    // Each sample shows the frame position one cycle behind the counter
    always @(negedge clk) begin
        if (sb_active) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s sb_underflow: no expected entry for SEG=%h DIG=%b", cur_test, SEG, DIG);
            end else begin
                cur = sb.pop_front();
                n_cmp++;
                if (SEG !== cur.seg) begin
                    n_bad++;
                    $display("FAIL %s seg: got %h want %h @%0t", cur.tag, SEG, cur.seg, $time);
                end
                n_cmp++;
                if (DIG !== cur.dig) begin
                    n_bad++;
                    $display("FAIL %s dig: got %b want %b @%0t", cur.tag, DIG, cur.dig, $time);
                end
                n_cmp++;
                if (o_frame !== cur.frame) begin
                    n_bad++;
                    $display("FAIL %s frame: got %b want %b @%0t", cur.tag, o_frame, cur.frame, $time);
                end
            end
        end
    end

    // Drive a new snapshot source and queue the full frame it will produce
    task automatic apply(input logic [11:0] d, input logic [2:0] dp, input logic [2:0] en);
        exp_t        e;
        int          s, c;
        logic [3:0]  nib;
        logic [11:0] hi;
        logic        lz;
        i_data = d;
        i_dp = dp;
        i_en_mask = en;
        for (int p = 0; p < 24; p++) begin
            s = p / 8;
            c = p % 8;
            nib = d[4*s +: 4];
            hi = d >> (4 * s);
            lz = LZB && s > 0 && hi == 12'h000;
            e.tag = cur_test;
            e.frame = p == 23;
            if (c >= 2 && en[s] && (!lz || dp[s])) begin
                e.seg = lz ? {dp[s], 7'h00} : {dp[s], tbl[nib][6:0]};
                e.dig = ~(3'b001 << s);
            end else begin
                e.seg = 8'h00;
                e.dig = 3'b111;
            end
            sb.push_back(e);
        end
    endtask

    task automatic frame_step(input int k, input logic [11:0] d, input logic [2:0] dp, input logic [2:0] en);
        repeat (k) @(negedge clk);
        #1;
        apply(d, dp, en);
        repeat (24 - k) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        cur_test = "reset";
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (SEG !== 8'h00) begin
                n_bad++;
                $display("FAIL reset seg: got %h want 00", SEG);
            end
            n_cmp++;
            if (DIG !== 3'b111) begin
                n_bad++;
                $display("FAIL reset dig: got %b want 111", DIG);
            end
            n_cmp++;
            if (o_frame !== 1'b0) begin
                n_bad++;
                $display("FAIL reset frame: got %b want 0", o_frame);
            end
        end
        #1;
        rst_n = 1'b1;
        cur_test = "scan_first";
        apply(12'h5A3, 3'b000, 3'b111);
        sb_active = 1'b1;
    endtask

    task automatic test_scan;
        cur_test = "scan";
        frame_step(1, 12'h5A3, 3'b000, 3'b111);
    endtask

    task automatic test_snapshot;
        cur_test = "snapshot";
        frame_step(9, 12'h111, 3'b000, 3'b111);
        frame_step(1, 12'h5A3, 3'b010, 3'b101);
    endtask

    task automatic test_dp_enable;
        cur_test = "dp_enable";
        frame_step(1, 12'h5A3, 3'b010, 3'b111);
        frame_step(1, 12'h007, 3'b000, 3'b111);
    endtask

    task automatic test_lzb;
        cur_test = "lzb";
        frame_step(1, 12'h000, 3'b000, 3'b111);
        frame_step(1, 12'h070, 3'b000, 3'b111);
        frame_step(1, 12'h070, 3'b100, 3'b111);
        repeat (24) @(negedge clk);
        #1;
        sb_active = 1'b0;
    endtask

    task automatic test_reset_mid;
        cur_test = "reset_mid";
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply(12'h5A3, 3'b000, 3'b111);
        sb_active = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        sb_active = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (DIG !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_mid async dig: got %b want 111", DIG);
        end
        n_cmp++;
        if (SEG !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid async seg: got %h want 00", SEG);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (DIG !== 3'b111 || o_frame !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid hold: got dig %b frame %b want 111 0", DIG, o_frame);
        end
        #1;
        rst_n = 1'b1;
        cur_test = "reset_mid_restart";
        apply(12'h5A3, 3'b000, 3'b111);
        sb_active = 1'b1;
        frame_step(1, 12'h5A3, 3'b000, 3'b111);
        repeat (24) @(negedge clk);
        #1;
        sb_active = 1'b0;
    endtask

    initial begin
        test_reset;
        test_scan;
        test_snapshot;
        test_dp_enable;
        test_lzb;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
